// File: rtl/acc_pkg.sv
// Shared types for the accumulator unit: opcode and shift-FSM state encodings.
package acc_pkg;

    typedef enum logic [3:0] {
        OpNop   = 4'd0,
        OpLoad  = 4'd1,
        OpLdimm = 4'd2,
        OpInc   = 4'd3,
        OpDec   = 4'd4,
        OpComp  = 4'd5,
        OpZero  = 4'd6,
        OpAdd   = 4'd7,
        OpSub   = 4'd8,
        OpAnd   = 4'd9,
        OpOr    = 4'd10,
        OpXor   = 4'd11,
        OpShr   = 4'd12,
        OpShl   = 4'd13,
        OpRor   = 4'd14,
        OpRsvd  = 4'd15
    } acc_op_e;

    typedef enum logic [0:0] {
        StIdle  = 1'b0,
        StShift = 1'b1
    } acc_state_e;

    // Multi-bit shift/rotate opcodes run one bit per cycle.
    function automatic logic is_shift_op(acc_op_e op);
        return (op == OpShr) || (op == OpShl) || (op == OpRor);
    endfunction

endpackage

// File: rtl/acc_unit_if.sv
// Controller <-> accumulator handshake and data bus.
interface acc_unit_if
    import acc_pkg::*;
#(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned IMM_W   = 8,
    parameter int unsigned SHAMT_W = $clog2(WIDTH)
) ();

    logic               op_valid;
    logic               op_ready;
    acc_op_e            op;
    logic [WIDTH-1:0]   data_in;
    logic [IMM_W-1:0]   imm;
    logic [SHAMT_W-1:0] shamt;
    logic [WIDTH-1:0]   acc_out;
    logic               done;
    logic               zero_flag;
    logic               neg_flag;
    logic               carry_flag;
    logic               ovf_flag;

    modport master (
        output op_valid, op, data_in, imm, shamt,
        input  op_ready, acc_out, done, zero_flag, neg_flag, carry_flag, ovf_flag
    );

    modport slave (
        input  op_valid, op, data_in, imm, shamt,
        output op_ready, acc_out, done, zero_flag, neg_flag, carry_flag, ovf_flag
    );

endinterface

// File: rtl/acc_alu.sv
// Combinational single-cycle result and flags for every non-iterating opcode.
module acc_alu
    import acc_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned IMM_W = 8
) (
    input  acc_op_e          op_i,
    input  logic [WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic [IMM_W-1:0] imm_i,
    output logic [WIDTH-1:0] res_o,
    output logic             carry_o,
    output logic             ovf_o,
    output logic             flags_we_o
);

    logic                    is_sub;
    logic [WIDTH-1:0]        operand;
    logic [WIDTH:0]          sum;
    logic signed [IMM_W-1:0] imm_s;
    logic                    add_ovf;
    logic                    sub_ovf;

    // INC/DEC reuse the adder with a constant one; bit WIDTH is carry or borrow.
    assign is_sub  = (op_i == OpDec) || (op_i == OpSub);
    assign operand = ((op_i == OpInc) || (op_i == OpDec)) ? WIDTH'(1) : data_i;
    assign sum     = is_sub ? ({1'b0, acc_i} - {1'b0, operand})
                            : ({1'b0, acc_i} + {1'b0, operand});
    assign imm_s   = imm_i;

    assign add_ovf = (acc_i[WIDTH-1] == operand[WIDTH-1]) && (sum[WIDTH-1] != acc_i[WIDTH-1]);
    assign sub_ovf = (acc_i[WIDTH-1] != operand[WIDTH-1]) && (sum[WIDTH-1] != acc_i[WIDTH-1]);

    // Opcode decode; shifts land here only with a zero count (acc kept, flags cleared).
    always_comb begin
        res_o      = acc_i;
        carry_o    = 1'b0;
        ovf_o      = 1'b0;
        flags_we_o = 1'b1;
        unique case (op_i)
            OpLoad:  res_o = data_i;
            OpLdimm: res_o = WIDTH'(imm_s);
            OpInc, OpAdd: begin
                res_o   = sum[WIDTH-1:0];
                carry_o = sum[WIDTH];
                ovf_o   = add_ovf;
            end
            OpDec, OpSub: begin
                res_o   = sum[WIDTH-1:0];
                carry_o = sum[WIDTH];
                ovf_o   = sub_ovf;
            end
            OpComp:  res_o = ~acc_i;
            OpZero:  res_o = '0;
            OpAnd:   res_o = acc_i & data_i;
            OpOr:    res_o = acc_i | data_i;
            OpXor:   res_o = acc_i ^ data_i;
            OpShr, OpShl, OpRor: res_o = acc_i;
            OpNop, OpRsvd: flags_we_o = 1'b0;
            default: flags_we_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/acc_unit.sv
// Accumulator unit: registers, handshake and the bit-serial shift/rotate FSM.
module acc_unit
    import acc_pkg::*;
#(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned IMM_W   = 8,
    parameter int unsigned SHAMT_W = $clog2(WIDTH)
) (
    input logic       clk,
    input logic       rst,
    acc_unit_if.slave bus
);

    acc_state_e         state_q;
    acc_op_e            sh_op_q;
    logic [SHAMT_W-1:0] cnt_q;
    logic [WIDTH-1:0]   acc_q;
    logic               carry_q;
    logic               ovf_q;
    logic               done_q;

    logic               accept;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_carry;
    logic               alu_ovf;
    logic               alu_flags_we;
    acc_op_e            step_op;
    logic [WIDTH-1:0]   step_res;
    logic               step_c;

    assign accept = bus.op_valid && (state_q == StIdle);

    acc_alu #(
        .WIDTH (WIDTH),
        .IMM_W (IMM_W)
    ) u_alu (
        .op_i       (bus.op),
        .acc_i      (acc_q),
        .data_i     (bus.data_in),
        .imm_i      (bus.imm),
        .res_o      (alu_res),
        .carry_o    (alu_carry),
        .ovf_o      (alu_ovf),
        .flags_we_o (alu_flags_we)
    );

    // One shift/rotate step; the first step uses the opcode being accepted.
    always_comb begin
        step_op  = (state_q == StIdle) ? bus.op : sh_op_q;
        step_res = acc_q;
        step_c   = 1'b0;
        unique case (step_op)
            OpShr: begin
                step_res = {acc_q[WIDTH-1], acc_q[WIDTH-1:1]};
                step_c   = acc_q[0];
            end
            OpShl: begin
                step_res = {acc_q[WIDTH-2:0], 1'b0};
                step_c   = acc_q[WIDTH-1];
            end
            OpRor: begin
                step_res = {acc_q[0], acc_q[WIDTH-1:1]};
                step_c   = acc_q[0];
            end
            default: begin
            end
        endcase
    end

    // State, accumulator, flags and done pulse; cnt_q counts steps still to run.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            sh_op_q <= OpNop;
            cnt_q   <= '0;
            acc_q   <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        if (is_shift_op(bus.op) && (bus.shamt != '0)) begin
                            acc_q   <= step_res;
                            carry_q <= step_c;
                            ovf_q   <= 1'b0;
                            sh_op_q <= bus.op;
                            if (bus.shamt == SHAMT_W'(1)) begin
                                done_q <= 1'b1;
                            end else begin
                                state_q <= StShift;
                                cnt_q   <= bus.shamt - SHAMT_W'(1);
                            end
                        end else begin
                            done_q <= 1'b1;
                            acc_q  <= alu_res;
                            if (alu_flags_we) begin
                                carry_q <= alu_carry;
                                ovf_q   <= alu_ovf;
                            end
                        end
                    end
                end
                StShift: begin
                    acc_q   <= step_res;
                    carry_q <= step_c;
                    cnt_q   <= cnt_q - SHAMT_W'(1);
                    if (cnt_q == SHAMT_W'(1)) begin
                        state_q <= StIdle;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.op_ready   = (state_q == StIdle);
    assign bus.acc_out    = acc_q;
    assign bus.done       = done_q;
    assign bus.zero_flag  = (acc_q == '0);
    assign bus.neg_flag   = acc_q[WIDTH-1];
    assign bus.carry_flag = carry_q;
    assign bus.ovf_flag   = ovf_q;

endmodule

// File: tb/tb_acc_unit.sv
// Randomised self-checking bench for acc_unit against an arithmetic reference model.
module tb_acc_unit;
    import acc_pkg::*;

    localparam int unsigned W = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    acc_unit_if #(.WIDTH(W), .IMM_W(8), .SHAMT_W(4)) bus ();

    acc_unit #(.WIDTH(W), .IMM_W(8), .SHAMT_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fails  = 0;

    // Reference state.
    logic [W-1:0] m_acc;
    logic         m_c;
    logic         m_v;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Value after shifting/rotating v by n bit positions, with the last bit out on top.
    function automatic logic [W:0] shifted(input int op, input logic [W-1:0] v, input int n);
        logic [W-1:0] r;
        logic         c;
        if (n == 0) return {1'b0, v};
        case (op)
            12: begin c = v[n-1];   r = W'($signed(v) >>> n); end
            13: begin c = v[W-n];   r = v << n; end
            default: begin c = v[n-1]; r = (v >> n) | (v << (W - n)); end
        endcase
        return {c, r};
    endfunction

    task automatic model_arith(input logic [W-1:0] b, input bit sub);
        longint ua, ub, sa, sb, s;
        ua = longint'(m_acc);
        ub = longint'(b);
        sa = longint'($signed(m_acc));
        sb = longint'($signed(b));
        if (!sub) begin
            m_c   = (ua + ub) > 65535;
            s     = sa + sb;
            m_acc = W'(ua + ub);
        end else begin
            m_c   = ub > ua;
            s     = sa - sb;
            m_acc = W'(ua - ub);
        end
        m_v = (s > 32767) || (s < -32768);
    endtask

    task automatic model_apply(input int op, input logic [W-1:0] d, input logic [7:0] im,
                               input int sh);
        logic [W:0] r;
        case (op)
            1:  begin m_acc = d;                      m_c = 0; m_v = 0; end
            2:  begin m_acc = {{8{im[7]}}, im};       m_c = 0; m_v = 0; end
            3:  model_arith(16'd1, 1'b0);
            4:  model_arith(16'd1, 1'b1);
            5:  begin m_acc = ~m_acc;                 m_c = 0; m_v = 0; end
            6:  begin m_acc = '0;                     m_c = 0; m_v = 0; end
            7:  model_arith(d, 1'b0);
            8:  model_arith(d, 1'b1);
            9:  begin m_acc = m_acc & d;              m_c = 0; m_v = 0; end
            10: begin m_acc = m_acc | d;              m_c = 0; m_v = 0; end
            11: begin m_acc = m_acc ^ d;              m_c = 0; m_v = 0; end
            12, 13, 14: begin
                r     = shifted(op, m_acc, sh);
                m_acc = r[W-1:0];
                m_c   = r[W];
                m_v   = 0;
            end
            default: begin end
        endcase
    endtask

    task automatic check_outputs(input string tag);
        check_eq({tag, "_acc"},   bus.acc_out,    m_acc);
        check_eq({tag, "_carry"}, bus.carry_flag, m_c);
        check_eq({tag, "_ovf"},   bus.ovf_flag,   m_v);
        check_eq({tag, "_zero"},  bus.zero_flag,  m_acc == '0);
        check_eq({tag, "_neg"},   bus.neg_flag,   m_acc[W-1]);
    endtask

    // Present one op, follow it to completion; junk holds an INC on the bus while busy.
    task automatic issue_op(input int op, input logic [W-1:0] d, input logic [7:0] im,
                            input int sh, input bit junk);
        logic [W-1:0] start;
        logic [W:0]   mid;
        int           lat;
        check_eq("pre_ready", bus.op_ready, 1'b1);
        bus.op_valid = 1'b1;
        bus.op       = acc_op_e'(4'(op));
        bus.data_in  = d;
        bus.imm      = im;
        bus.shamt    = 4'(sh);
        start        = m_acc;
        lat          = (op >= 12 && op <= 14 && sh > 0) ? sh : 1;
        tick();
        if (junk) begin
            bus.op      = OpInc;
            bus.data_in = W'($urandom);
            bus.shamt   = 4'($urandom);
        end else begin
            bus.op_valid = 1'b0;
        end
        for (int i = 1; i < lat; i++) begin
            mid = shifted(op, start, i);
            check_eq("busy_ready", bus.op_ready, 1'b0);
            check_eq("busy_done",  bus.done,     1'b0);
            check_eq("busy_acc",   bus.acc_out,  mid[W-1:0]);
            tick();
        end
        bus.op_valid = 1'b0;
        model_apply(op, d, im, sh);
        check_eq("done_pulse",  bus.done,     1'b1);
        check_eq("done_ready",  bus.op_ready, 1'b1);
        check_outputs("result");
    endtask

    initial begin
        bus.op_valid = 1'b0;
        bus.op       = OpNop;
        bus.data_in  = '0;
        bus.imm      = '0;
        bus.shamt    = '0;
        m_acc = '0;
        m_c   = 1'b0;
        m_v   = 1'b0;

        // Reset state.
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check_eq("rst_acc",   bus.acc_out,    16'h0000);
        check_eq("rst_zero",  bus.zero_flag,  1'b1);
        check_eq("rst_neg",   bus.neg_flag,   1'b0);
        check_eq("rst_carry", bus.carry_flag, 1'b0);
        check_eq("rst_ovf",   bus.ovf_flag,   1'b0);
        check_eq("rst_ready", bus.op_ready,   1'b1);
        check_eq("rst_done",  bus.done,       1'b0);

        // Immediate load with sign extension, then increment through the wrap.
        issue_op(2, '0, 8'hF0, 0, 1'b0);
        check_eq("ldimm_val", bus.acc_out, 16'hFFF0);
        check_eq("ldimm_neg", bus.neg_flag, 1'b1);
        for (int i = 0; i < 16; i++) issue_op(3, '0, '0, 0, 1'b0);
        check_eq("inc_wrap_acc",   bus.acc_out,    16'h0000);
        check_eq("inc_wrap_carry", bus.carry_flag, 1'b1);
        check_eq("inc_wrap_zero",  bus.zero_flag,  1'b1);
        tick();
        check_eq("done_drops", bus.done, 1'b0);

        // Signed overflow on ADD, borrow on SUB.
        issue_op(1, 16'h7FFF, '0, 0, 1'b0);
        issue_op(7, 16'h0001, '0, 0, 1'b0);
        check_eq("add_ovf_acc", bus.acc_out,  16'h8000);
        check_eq("add_ovf_v",   bus.ovf_flag, 1'b1);
        check_eq("add_ovf_c",   bus.carry_flag, 1'b0);
        issue_op(1, 16'h0003, '0, 0, 1'b0);
        issue_op(8, 16'h0005, '0, 0, 1'b0);
        check_eq("sub_borrow_acc", bus.acc_out,    16'hFFFE);
        check_eq("sub_borrow_c",   bus.carry_flag, 1'b1);

        // Arithmetic shift by 4 with an INC held on the bus while busy.
        issue_op(1, 16'h8000, '0, 0, 1'b0);
        issue_op(12, '0, '0, 4, 1'b1);
        check_eq("shr4_acc", bus.acc_out,    16'hF800);
        check_eq("shr4_c",   bus.carry_flag, 1'b0);

        // Single-step rotate, then a zero-count rotate.
        issue_op(1, 16'h0001, '0, 0, 1'b0);
        issue_op(14, '0, '0, 1, 1'b0);
        check_eq("ror1_acc", bus.acc_out,    16'h8000);
        check_eq("ror1_c",   bus.carry_flag, 1'b1);
        issue_op(14, '0, '0, 0, 1'b0);
        check_eq("ror0_acc", bus.acc_out,    16'h8000);
        check_eq("ror0_c",   bus.carry_flag, 1'b0);

        // Reset in the middle of a shift aborts it without a done pulse.
        issue_op(1, 16'h1234, '0, 0, 1'b0);
        bus.op_valid = 1'b1;
        bus.op       = OpShl;
        bus.shamt    = 4'd3;
        tick();
        bus.op_valid = 1'b0;
        check_eq("shl_busy", bus.op_ready, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_acc = '0;
        m_c   = 1'b0;
        m_v   = 1'b0;
        check_eq("abort_acc",   bus.acc_out,  16'h0000);
        check_eq("abort_ready", bus.op_ready, 1'b1);
        check_eq("abort_done",  bus.done,     1'b0);
        tick();
        check_eq("abort_nodone", bus.done, 1'b0);
        issue_op(15, 16'hABCD, 8'h55, 5, 1'b0);

        // Randomised ops with idle gaps.
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 4) == 0) begin
                bus.op_valid = 1'b0;
                bus.op       = acc_op_e'(4'($urandom));
                bus.data_in  = W'($urandom);
                tick();
                check_eq("idle_done", bus.done, 1'b0);
                check_outputs("idle");
            end else begin
                issue_op(int'($urandom_range(0, 15)), W'($urandom), 8'($urandom),
                         int'($urandom_range(0, 15)), 1'($urandom));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
